// File: rtl/boot_reset_sequencer.sv
// boot_reset_sequencer
//   Generates the Propeller core reset from PLL lock, a bouncing pushbutton and
//   a serial RTS/DTR request. All asynchronous inputs are synchronized, the
//   button is debounced, RTS is edge-detected, and a LOCK -> HOLD -> RUN
//   sequencer stretches every reset to at least STRETCH_CYCLES.
//
// Ports
//   clock_160    in   sole clock
//   inp_resn     in   asynchronous active-low reset
//   pll_locked   in   raw PLL lock indicator (async)
//   btn_resn     in   raw reset pushbutton, active low (async, bouncing)
//   rts_n        in   raw serial RTS/DTR reset request, active low (async)
//   prop_resn    out  registered active-low Propeller reset (1 only in RUN)
//   seq_state    out  0 LOCK, 1 HOLD, 2 RUN
//   reset_cause  out  0 lock/power, 1 button, 2 rts
//   reset_count  out  saturating count of RUN->HOLD transitions
module boot_reset_sequencer #(
    parameter int DEB_CYCLES     = 65535,
    parameter int LOCK_CYCLES    = 16000,
    parameter int STRETCH_CYCLES = 1600
) (
    input  logic       clock_160,
    input  logic       inp_resn,
    input  logic       pll_locked,
    input  logic       btn_resn,
    input  logic       rts_n,
    output logic       prop_resn,
    output logic [1:0] seq_state,
    output logic [1:0] reset_cause,
    output logic [7:0] reset_count
);

    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam int STR_W  = $clog2(STRETCH_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX  = LOCK_W'(LOCK_CYCLES);
    localparam logic [STR_W-1:0]  STR_LOAD  = STR_W'(STRETCH_CYCLES);

    localparam logic [1:0] CAUSE_LOCK = 2'd0;
    localparam logic [1:0] CAUSE_BTN  = 2'd1;
    localparam logic [1:0] CAUSE_RTS  = 2'd2;

    typedef enum logic [1:0] {
        ST_LOCK = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Saturating increment for the 8-bit reset counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            return value;
        end else begin
            return value + 8'd1;
        end
    endfunction

    logic              pll_meta_r, pll_sync_r;
    logic              btn_meta_r, btn_sync_r;
    logic              rts_meta_r, rts_sync_r, rts_prev_r, rts_fall_r;
    logic              btn_deb_r, btn_deb_nxt_s;
    logic [DEB_W-1:0]  deb_cnt_r, deb_cnt_nxt_s;
    logic [LOCK_W-1:0] lock_cnt_r, lock_cnt_nxt_s;
    logic              lock_ok_s;
    state_t            state_r, state_nxt_s;
    logic [STR_W-1:0]  stretch_r, stretch_nxt_s;
    logic [1:0]        cause_r, cause_nxt_s;
    logic [7:0]        count_r, count_nxt_s;
    logic              prop_resn_r, prop_resn_nxt_s;

    // Two-flop synchronizers plus RTS falling-edge pulse (registered so the
    // edge detector never sees the metastable first stage).
    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            pll_meta_r <= 1'b0;
            pll_sync_r <= 1'b0;
            btn_meta_r <= 1'b1;
            btn_sync_r <= 1'b1;
            rts_meta_r <= 1'b1;
            rts_sync_r <= 1'b1;
            rts_prev_r <= 1'b1;
            rts_fall_r <= 1'b0;
        end else begin
            pll_meta_r <= pll_locked;
            pll_sync_r <= pll_meta_r;
            btn_meta_r <= btn_resn;
            btn_sync_r <= btn_meta_r;
            rts_meta_r <= rts_n;
            rts_sync_r <= rts_meta_r;
            rts_prev_r <= rts_sync_r;
            rts_fall_r <= rts_prev_r & ~rts_sync_r;
        end
    end

    // Debounce: accept a new button level on the DEB_CYCLES-th consecutive
    // differing cycle; any agreeing cycle restarts the count.
    always_comb begin
        btn_deb_nxt_s = btn_deb_r;
        deb_cnt_nxt_s = {DEB_W{1'b0}};
        if (btn_sync_r != btn_deb_r) begin
            if (deb_cnt_r >= DEB_LAST) begin
                btn_deb_nxt_s = btn_sync_r;
                deb_cnt_nxt_s = {DEB_W{1'b0}};
            end else begin
                deb_cnt_nxt_s = deb_cnt_r + DEB_W'(1'b1);
            end
        end else begin
            deb_cnt_nxt_s = {DEB_W{1'b0}};
        end
    end

    // Lock qualification: counter holds the number of earlier consecutive
    // locked cycles, so lock_ok fires on the LOCK_CYCLES-th one including now.
    always_comb begin
        lock_cnt_nxt_s = lock_cnt_r;
        if (!pll_sync_r) begin
            lock_cnt_nxt_s = {LOCK_W{1'b0}};
        end else if (lock_cnt_r < LOCK_MAX) begin
            lock_cnt_nxt_s = lock_cnt_r + LOCK_W'(1'b1);
        end else begin
            lock_cnt_nxt_s = lock_cnt_r;
        end
        lock_ok_s = pll_sync_r && (lock_cnt_r >= LOCK_LAST);
    end

    // Sequencer next state, stretch counter and cause/count bookkeeping.
    always_comb begin
        state_nxt_s   = state_r;
        stretch_nxt_s = stretch_r;
        cause_nxt_s   = cause_r;
        count_nxt_s   = count_r;
        case (state_r)
            ST_LOCK: begin
                if (lock_ok_s) begin
                    state_nxt_s   = ST_HOLD;
                    stretch_nxt_s = STR_LOAD;
                end else begin
                    stretch_nxt_s = {STR_W{1'b0}};
                end
            end
            ST_HOLD: begin
                if (!pll_sync_r) begin
                    state_nxt_s   = ST_LOCK;
                    stretch_nxt_s = {STR_W{1'b0}};
                    cause_nxt_s   = CAUSE_LOCK;
                end else if (rts_fall_r) begin
                    stretch_nxt_s = STR_LOAD;
                end else if (stretch_r == {STR_W{1'b0}}) begin
                    if (btn_deb_r) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end else begin
                    stretch_nxt_s = stretch_r - STR_W'(1'b1);
                end
            end
            ST_RUN: begin
                if (!pll_sync_r) begin
                    state_nxt_s = ST_LOCK;
                    cause_nxt_s = CAUSE_LOCK;
                end else if (!btn_deb_r) begin
                    state_nxt_s   = ST_HOLD;
                    stretch_nxt_s = STR_LOAD;
                    cause_nxt_s   = CAUSE_BTN;
                    count_nxt_s   = sat_inc8(count_r);
                end else if (rts_fall_r) begin
                    state_nxt_s   = ST_HOLD;
                    stretch_nxt_s = STR_LOAD;
                    cause_nxt_s   = CAUSE_RTS;
                    count_nxt_s   = sat_inc8(count_r);
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s   = ST_LOCK;
                stretch_nxt_s = {STR_W{1'b0}};
                cause_nxt_s   = CAUSE_LOCK;
            end
        endcase
        prop_resn_nxt_s = (state_nxt_s == ST_RUN);
    end

    // State, counters and the glitch-free reset output share one edge.
    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            btn_deb_r   <= 1'b1;
            deb_cnt_r   <= {DEB_W{1'b0}};
            lock_cnt_r  <= {LOCK_W{1'b0}};
            state_r     <= ST_LOCK;
            stretch_r   <= {STR_W{1'b0}};
            cause_r     <= CAUSE_LOCK;
            count_r     <= 8'd0;
            prop_resn_r <= 1'b0;
        end else begin
            btn_deb_r   <= btn_deb_nxt_s;
            deb_cnt_r   <= deb_cnt_nxt_s;
            lock_cnt_r  <= lock_cnt_nxt_s;
            state_r     <= state_nxt_s;
            stretch_r   <= stretch_nxt_s;
            cause_r     <= cause_nxt_s;
            count_r     <= count_nxt_s;
            prop_resn_r <= prop_resn_nxt_s;
        end
    end

    assign prop_resn   = prop_resn_r;
    assign seq_state   = state_r;
    assign reset_cause = cause_r;
    assign reset_count = count_r;

endmodule

// File: tb/tb_boot_reset_sequencer.sv
// Self-checking bench for boot_reset_sequencer with small parameters.
// A behavioural model (input history delays, run lengths and a "ready" edge
// number for the stretch) predicts every output on every cycle; directed
// literal checks pin the key timings.
module tb_boot_reset_sequencer;

    localparam int DEB  = 4;
    localparam int LOCK = 8;
    localparam int STR  = 16;

    logic       clk = 1'b0;
    logic       rst_n, pll, btn, rts;
    logic       prop_resn;
    logic [1:0] seq_state, reset_cause;
    logic [7:0] reset_count;

    always #5 clk = ~clk;

    boot_reset_sequencer #(
        .DEB_CYCLES    (DEB),
        .LOCK_CYCLES   (LOCK),
        .STRETCH_CYCLES(STR)
    ) dut (
        .clock_160  (clk),
        .inp_resn   (rst_n),
        .pll_locked (pll),
        .btn_resn   (btn),
        .rts_n      (rts),
        .prop_resn  (prop_resn),
        .seq_state  (seq_state),
        .reset_cause(reset_cause),
        .reset_count(reset_count)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;   // clock edges since reset release

    // model: raw input samples, index 0 = sampled one edge ago
    bit hp[4], hb[4], hr[4];
    int m_state, m_cause, m_count, m_ready, m_lock_run, m_diff_run;
    bit m_deb;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_init();
        for (int i = 0; i < 4; i++) begin
            hp[i] = 1'b0;
            hb[i] = 1'b1;
            hr[i] = 1'b1;
        end
        m_state = 0; m_cause = 0; m_count = 0; m_ready = 0;
        m_lock_run = 0; m_diff_run = 0; m_deb = 1'b1; cyc = 0;
    endtask

    // Synchronized value seen at edge e is the raw sample of edge e-2; the
    // sequencer acts on an RTS fall when raw(e-4)=1 and raw(e-3)=0.
    task automatic model_step();
        bit s_pll, s_btn, fall, lock_ok, deb_seen;
        cyc++;
        s_pll = hp[1];
        s_btn = hb[1];
        fall  = hr[3] && !hr[2];
        if (s_pll) m_lock_run = (m_lock_run < 100000) ? m_lock_run + 1 : m_lock_run;
        else       m_lock_run = 0;
        lock_ok  = (m_lock_run >= LOCK);
        deb_seen = m_deb;
        case (m_state)
            0: begin
                if (lock_ok) begin m_state = 1; m_ready = cyc + STR + 1; end
            end
            1: begin
                if (!s_pll) begin m_state = 0; m_cause = 0; end
                else if (fall) m_ready = cyc + STR + 1;
                else if (cyc >= m_ready && deb_seen) m_state = 2;
            end
            2: begin
                if (!s_pll) begin m_state = 0; m_cause = 0; end
                else if (!deb_seen || fall) begin
                    m_state = 1;
                    m_ready = cyc + STR + 1;
                    m_cause = !deb_seen ? 1 : 2;
                    if (m_count < 255) m_count++;
                end
            end
            default: ;
        endcase
        if (s_btn != m_deb) begin
            m_diff_run++;
            if (m_diff_run >= DEB) begin m_deb = s_btn; m_diff_run = 0; end
        end else begin
            m_diff_run = 0;
        end
        for (int i = 3; i > 0; i--) begin
            hp[i] = hp[i-1]; hb[i] = hb[i-1]; hr[i] = hr[i-1];
        end
        hp[0] = pll; hb[0] = btn; hr[0] = rts;
    endtask

    // One clock: advance model on the edge, compare #1 later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("prop_resn",   int'(prop_resn),   (m_state == 2) ? 1 : 0);
        check("seq_state",   int'(seq_state),   m_state);
        check("reset_cause", int'(reset_cause), m_cause);
        check("reset_count", int'(reset_count), m_count);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_run(input int budget);
        int n;
        n = 0;
        while (prop_resn !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (prop_resn !== 1'b1) begin
            errors++;
            $display("FAIL wait_run at edge %0d: prop_resn=%0b required 1 within %0d cycles", cyc, prop_resn, budget);
        end
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_prop",  int'(prop_resn),   0);
        check("rst_state", int'(seq_state),   0);
        check("rst_cause", int'(reset_cause), 0);
        check("rst_count", int'(reset_count), 0);
        model_init();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int rts_hold, btn_hold, pll_hold;

    initial begin
        rst_n = 1'b1; pll = 1'b1; btn = 1'b1; rts = 1'b1;
        model_init();
        #2 rst_n = 1'b0;
        #1;
        check("por_prop",  int'(prop_resn),   0);
        check("por_state", int'(seq_state),   0);
        check("por_cause", int'(reset_cause), 0);
        check("por_count", int'(reset_count), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // power-up: LOCK for 10 cycles, HOLD for 17, RUN from edge 27
        ticks(9);
        check("pu_state_e9", int'(seq_state), 0);
        tick();
        check("pu_state_e10", int'(seq_state), 1);
        ticks(16);
        check("pu_prop_e26", int'(prop_resn), 0);
        tick();
        check("pu_prop_e27",  int'(prop_resn),   1);
        check("pu_state_e27", int'(seq_state),   2);
        check("pu_count",     int'(reset_count), 0);
        check("pu_cause",     int'(reset_cause), 0);

        // rts pulse: latency N+3, then a second fall lands on stretch==0
        ticks(3);
        rts = 1'b0; tick();
        rts = 1'b1; ticks(2);
        check("rts_prop_n2", int'(prop_resn), 1);
        tick();
        check("rts_prop_n3", int'(prop_resn),   0);
        check("rts_cause",   int'(reset_cause), 2);
        check("rts_count",   int'(reset_count), 1);
        ticks(13);
        rts = 1'b0; tick();
        rts = 1'b1; ticks(3);
        check("reload_prop_n20",  int'(prop_resn), 0);
        check("reload_state_n20", int'(seq_state), 1);
        ticks(16);
        check("reload_prop_n36", int'(prop_resn), 0);
        tick();
        check("reload_prop_n37", int'(prop_resn),   1);
        check("reload_count",    int'(reset_count), 1);

        // rts held low 100 cycles -> exactly one reset
        rts = 1'b0; ticks(100);
        rts = 1'b1; wait_run(40);
        check("rts_held_count", int'(reset_count), 2);

        // short button glitch ignored, long press resets after 6 cycles
        btn = 1'b0; ticks(3);
        btn = 1'b1; ticks(20);
        check("btn_short_state", int'(seq_state),   2);
        check("btn_short_count", int'(reset_count), 2);
        btn = 1'b0; ticks(6);
        check("btn_prop_n5", int'(prop_resn), 1);
        tick();
        check("btn_prop_n6", int'(prop_resn),   0);
        check("btn_cause",   int'(reset_cause), 1);
        check("btn_count",   int'(reset_count), 3);
        ticks(43);
        btn = 1'b1; ticks(6);
        check("btn_rel_n55", int'(prop_resn), 0);
        tick();
        check("btn_rel_n56", int'(prop_resn), 1);

        // lock loss together with button press: lock wins, no count
        pll = 1'b0; btn = 1'b0; tick();
        tick();
        check("ll_state_n1", int'(seq_state), 2);
        tick();
        check("ll_state_n2", int'(seq_state),   0);
        check("ll_cause",    int'(reset_cause), 0);
        check("ll_count",    int'(reset_count), 3);
        ticks(2);
        pll = 1'b1; ticks(9);
        check("relock_m8", int'(seq_state), 0);
        tick();
        check("relock_m9", int'(seq_state), 1);
        ticks(30);
        check("btn_hold_state", int'(seq_state), 1);
        btn = 1'b1; wait_run(40);
        check("relock_count", int'(reset_count), 3);
        check("relock_cause", int'(reset_cause), 0);

        // async reset in the middle of a stretch
        rts = 1'b0; tick();
        rts = 1'b1; ticks(8);
        check("pre_rst_count", int'(reset_count), 4);
        do_reset();
        wait_run(60);
        check("post_rst_count", int'(reset_count), 0);

        // randomized traffic
        rts_hold = 0; btn_hold = 0; pll_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (rts_hold > 0) rts_hold--;
            else if ($urandom_range(0, 39) == 0) rts_hold = $urandom_range(1, 6);
            if (btn_hold > 0) btn_hold--;
            else if ($urandom_range(0, 59) == 0) btn_hold = $urandom_range(1, 12);
            if (pll_hold > 0) pll_hold--;
            else if ($urandom_range(0, 299) == 0) pll_hold = $urandom_range(1, 4);
            rts = (rts_hold == 0);
            btn = (btn_hold == 0);
            pll = (pll_hold == 0);
            tick();
        end

        // saturation with 260 rts resets
        pll = 1'b1; btn = 1'b1; rts = 1'b1;
        ticks(5);
        wait_run(200);
        for (int i = 0; i < 260; i++) begin
            rts = 1'b0; tick();
            rts = 1'b1; ticks(3);
            wait_run(40);
        end
        check("sat_count", int'(reset_count), 255);
        check("sat_state", int'(seq_state),   2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/boot_reset_sequencer.md
BOOT_RESET_SEQUENCER -- requirements
Module: boot_reset_sequencer

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 65535: consecutive cycles a synchronized btn_resn change must persist to be accepted; must be >= 1.
REQ-002 SHALL have parameter LOCK_CYCLES, default 16000: consecutive cycles synchronized pll_locked must be 1 to qualify the clock; must be >= 1.
REQ-003 SHALL have parameter STRETCH_CYCLES, default 1600: minimum Propeller reset hold time in cycles (10 us at 160 MHz); must be >= 1.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clock_160 input 1 (sole clock); inp_resn input 1 (async assert, active low).
REQ-005 SHALL have pll_locked input 1: raw PLL lock indicator, asynchronous.
REQ-006 SHALL have btn_resn input 1: raw reset pushbutton, active low, asynchronous, bouncing.
REQ-007 SHALL have rts_n input 1: raw serial RTS/DTR reset request, active low, asynchronous, edge-significant.
REQ-008 SHALL have prop_resn output 1: registered active-low reset to the Propeller core.
REQ-009 SHALL have seq_state output 2: current state (0 LOCK, 1 HOLD, 2 RUN).
REQ-010 SHALL have reset_cause output 2: cause of most recent reset (0 lock/power, 1 button, 2 rts).
REQ-011 SHALL have reset_count output 8: saturating count of RUN->HOLD transitions.

Function
REQ-012 SHALL pass pll_locked, btn_resn and rts_n each through a 2-flop synchronizer; no raw input may reach any other logic.
REQ-013 SHALL debounce: btn_deb changes only after synchronized btn_resn differs from btn_deb for DEB_CYCLES consecutive cycles; any matching cycle clears the debounce counter.
REQ-014 SHALL form rts_fall as a one-cycle pulse when synchronized rts_n is 0 and its prior-cycle value was 1; a held-low rts_n produces no further pulses.
REQ-015 SHALL count consecutive synchronized pll_locked=1 cycles; lock_ok asserts when count reaches LOCK_CYCLES; any 0 clears count and lock_ok.
REQ-016 State LOCK: prop_resn=0; button and rts ignored; on lock_ok go to HOLD.
REQ-017 State HOLD: prop_resn=0; stretch counter loaded with STRETCH_CYCLES on entry and decremented by 1 per cycle down to 0; rts_fall reloads it.
REQ-018 HOLD -> RUN when stretch counter is 0, btn_deb=1 and no rts_fall in the same cycle; button held (btn_deb=0) keeps HOLD indefinitely.
REQ-019 State RUN: prop_resn=1; on btn_deb=0 go to HOLD with cause 1; on rts_fall go to HOLD with cause 2; if both in same cycle, cause 1.
REQ-020 Loss of lock (synchronized pll_locked=0) in HOLD or RUN SHALL go to LOCK with cause 0 and has priority over every other event.
REQ-021 prop_resn SHALL be a flop updated on the same edge as the state register, equal to 1 only while state is RUN; never glitches.
REQ-022 Latency: rts_n low sampled on edge N SHALL drive prop_resn low on edge N+3 when in RUN.
REQ-023 reset_count SHALL increment on each RUN->HOLD transition and hold at 255; LOCK transitions do not count.
REQ-024 Counter widths SHALL be clog2(parameter+1); no counter may wrap.

Reset
REQ-025 inp_resn=0 SHALL immediately force: state LOCK, prop_resn 0, reset_cause 0, reset_count 0, all counters 0, btn_deb 1, synchronizers pll 0 / btn 1 / rts 1.
REQ-026 Assertion of inp_resn mid-operation SHALL abort any stretch or debounce in progress; after release the full LOCK qualification repeats.

Verification (DEB_CYCLES=4, LOCK_CYCLES=8, STRETCH_CYCLES=16)
REQ-027 Power-up, pll_locked=1, btn/rts high -> prop_resn 0 through LOCK (2 sync + 8) and HOLD (16+1), then 1; seq_state=2, reset_count=0, cause=0.
REQ-028 In RUN, rts_n low 1 cycle -> prop_resn 0 at edge N+3, high again after 16-cycle stretch; cause=2, reset_count=1; rts held low 100 cycles yields only one reset.
REQ-029 In RUN, btn_resn low 3 cycles -> no reset; low 50 cycles -> reset after 2+4 cycles, held until button debounced-released and stretch expired; cause=1.
REQ-030 rts_fall on the cycle stretch counter reaches 0 -> stays HOLD, counter reloaded to 16, prop_resn 0 for 16 more cycles.
REQ-031 pll_locked drops during HOLD or RUN, simultaneous with button press -> state LOCK, cause=0, reset_count unchanged; relock needs 8 clean cycles.
REQ-032 inp_resn pulsed low mid-stretch -> all outputs to reset values asynchronously; reset_count 255 saturation checked with 260 rts pulses.
